// File: rtl/axi_lite_decoder_if.sv
// AXI-lite channel bundle shared by the decoder's upstream and downstream ports.
// master drives requests, slave drives responses.
interface axi_lite_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp,
      input  arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, rready,
      output awready, wready, bvalid, bresp,
      output arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_decoder.sv
// 1:2 AXI-lite address decoder, one transaction in flight.
// Unmapped addresses are answered locally with DECERR.
module axi_lite_decoder #(
   parameter logic [31:0] S0_BASE = 32'h0000_0000,
   parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
   parameter logic [31:0] S1_BASE = 32'h1000_0000,
   parameter logic [31:0] S1_MASK = 32'hFFFF_F000
) (
   input  logic       clk,
   input  logic       rst,
   axi_lite_if.slave  in,
   axi_lite_if.master s0,
   axi_lite_if.master s1
);

   typedef enum logic [3:0] {
      IDLE, RD_S0, RD_S1, RD_ERR_A, RD_ERR_R,
      WR_S0, WR_S1, WR_ERR_AW, WR_ERR_B
   } state_t;

   state_t state;
   logic   aw_done;
   logic   w_done;

   logic ar_s0, ar_s1, aw_s0, aw_s1;
   assign ar_s0 = (in.araddr & S0_MASK) == S0_BASE;
   assign ar_s1 = (in.araddr & S1_MASK) == S1_BASE;
   assign aw_s0 = (in.awaddr & S0_MASK) == S0_BASE;
   assign aw_s1 = (in.awaddr & S1_MASK) == S1_BASE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               aw_done <= 1'b0;
               w_done  <= 1'b0;
               if (in.arvalid)
                  state <= ar_s0 ? RD_S0 : ar_s1 ? RD_S1 : RD_ERR_A;
               else if (in.awvalid)
                  state <= aw_s0 ? WR_S0 : aw_s1 ? WR_S1 : WR_ERR_AW;
            end
            RD_S0, RD_S1:
               if (in.rvalid && in.rready) state <= IDLE;
            WR_S0, WR_S1:
               if (in.bvalid && in.bready) state <= IDLE;
            RD_ERR_A:
               state <= RD_ERR_R;
            RD_ERR_R:
               if (in.rready) state <= IDLE;
            WR_ERR_AW: begin
               if (in.awvalid) aw_done <= 1'b1;
               if (in.wvalid)  w_done  <= 1'b1;
               if ((aw_done || in.awvalid) && (w_done || in.wvalid))
                  state <= WR_ERR_B;
            end
            WR_ERR_B:
               if (in.bready) state <= IDLE;
            default:
               state <= IDLE;
         endcase
      end
   end

   logic rd0, rd1, wr0, wr1, rerr_a, rerr_r, werr_aw, werr_b;
   assign rd0     = state == RD_S0;
   assign rd1     = state == RD_S1;
   assign wr0     = state == WR_S0;
   assign wr1     = state == WR_S1;
   assign rerr_a  = state == RD_ERR_A;
   assign rerr_r  = state == RD_ERR_R;
   assign werr_aw = state == WR_ERR_AW;
   assign werr_b  = state == WR_ERR_B;

   // Requests to each slave are gated by the registered selection only.
   assign s0.arvalid = rd0 & in.arvalid;
   assign s0.araddr  = rd0 ? in.araddr : '0;
   assign s0.rready  = rd0 & in.rready;
   assign s0.awvalid = wr0 & in.awvalid;
   assign s0.awaddr  = wr0 ? in.awaddr : '0;
   assign s0.wvalid  = wr0 & in.wvalid;
   assign s0.wdata   = wr0 ? in.wdata : '0;
   assign s0.wstrb   = wr0 ? in.wstrb : '0;
   assign s0.bready  = wr0 & in.bready;

   assign s1.arvalid = rd1 & in.arvalid;
   assign s1.araddr  = rd1 ? in.araddr : '0;
   assign s1.rready  = rd1 & in.rready;
   assign s1.awvalid = wr1 & in.awvalid;
   assign s1.awaddr  = wr1 ? in.awaddr : '0;
   assign s1.wvalid  = wr1 & in.wvalid;
   assign s1.wdata   = wr1 ? in.wdata : '0;
   assign s1.wstrb   = wr1 ? in.wstrb : '0;
   assign s1.bready  = wr1 & in.bready;

   assign in.arready = rd0 ? s0.arready : rd1 ? s1.arready : rerr_a;
   assign in.rvalid  = rd0 ? s0.rvalid  : rd1 ? s1.rvalid  : rerr_r;
   assign in.rdata   = rd0 ? s0.rdata   : rd1 ? s1.rdata   : '0;
   assign in.rresp   = rd0 ? s0.rresp   : rd1 ? s1.rresp
                     : rerr_r ? 2'b11 : 2'b00;

   assign in.awready = wr0 ? s0.awready : wr1 ? s1.awready
                     : werr_aw & in.awvalid & ~aw_done;
   assign in.wready  = wr0 ? s0.wready : wr1 ? s1.wready
                     : werr_aw & in.wvalid & ~w_done;
   assign in.bvalid  = wr0 ? s0.bvalid : wr1 ? s1.bvalid : werr_b;
   assign in.bresp   = wr0 ? s0.bresp  : wr1 ? s1.bresp
                     : werr_b ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_axi_lite_decoder.sv
// Directed bench for axi_lite_decoder: routing, DECERR paths,
// arbitration between read and write, and mid-transaction reset.
module tb_axi_lite_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_lite_if up ();
   axi_lite_if m0 ();
   axi_lite_if m1 ();

   axi_lite_decoder dut (
      .clk (clk),
      .rst (rst),
      .in  (up),
      .s0  (m0),
      .s1  (m1)
   );

   int errors = 0;
   int checks = 0;

   logic mon_clr = 1'b1;
   logic s0_seen, s1_seen, s1_ar_seen;
   int   b_hs;

   always @(posedge clk) begin
      if (mon_clr) begin
         s0_seen    <= 1'b0;
         s1_seen    <= 1'b0;
         s1_ar_seen <= 1'b0;
         b_hs       <= 0;
      end else begin
         if (m0.arvalid | m0.awvalid | m0.wvalid) s0_seen <= 1'b1;
         if (m1.arvalid | m1.awvalid | m1.wvalid) s1_seen <= 1'b1;
         if (m1.arvalid) s1_ar_seen <= 1'b1;
         if (up.bvalid && up.bready) b_hs <= b_hs + 1;
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   initial begin
      {up.arvalid, up.awvalid, up.wvalid, up.rready, up.bready} = '0;
      up.araddr = '0; up.awaddr = '0; up.wdata = '0; up.wstrb = '0;
      {m0.arready, m0.rvalid, m0.awready, m0.wready, m0.bvalid} = '0;
      m0.rdata = '0; m0.rresp = '0; m0.bresp = '0;
      {m1.arready, m1.rvalid, m1.awready, m1.wready, m1.bvalid} = '0;
      m1.rdata = '0; m1.rresp = '0; m1.bresp = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_arready", 32'(up.arready), 0);
      chk("rst_rvalid",  32'(up.rvalid), 0);
      chk("rst_bvalid",  32'(up.bvalid), 0);
      chk("rst_s0_arv",  32'(m0.arvalid), 0);
      chk("rst_s1_awv",  32'(m1.awvalid), 0);
      chk("rst_rdata",   up.rdata, 0);

      // 1) read from s0
      clr_mon();
      up.araddr = 32'h0000_0010; up.arvalid = 1; up.rready = 1;
      #1;
      chk("t1_bubble_arready", 32'(up.arready), 0);
      chk("t1_bubble_s0arv",   32'(m0.arvalid), 0);
      tick();
      chk("t1_s0_arvalid", 32'(m0.arvalid), 1);
      chk("t1_s0_araddr",  m0.araddr, 32'h0000_0010);
      m0.arready = 1; #1;
      chk("t1_arready", 32'(up.arready), 1);
      tick();
      up.arvalid = 0; m0.arready = 0;
      m0.rvalid = 1; m0.rdata = 32'hDEAD_BEEF; m0.rresp = 2'b00;
      #1;
      chk("t1_rvalid", 32'(up.rvalid), 1);
      chk("t1_rdata",  up.rdata, 32'hDEAD_BEEF);
      chk("t1_rresp",  32'(up.rresp), 0);
      chk("t1_s0_rready", 32'(m0.rready), 1);
      tick();
      m0.rvalid = 0; #1;
      chk("t1_s0_rready_idle", 32'(m0.rready), 0);
      chk("t1_s1_ar_never", 32'(s1_ar_seen), 0);

      // 2) write to s1
      clr_mon();
      up.awaddr = 32'h1000_0004; up.awvalid = 1;
      up.wdata = 32'h5A; up.wstrb = 4'h1; up.wvalid = 1; up.bready = 1;
      tick();
      chk("t2_s1_awvalid", 32'(m1.awvalid), 1);
      chk("t2_s1_awaddr",  m1.awaddr, 32'h1000_0004);
      chk("t2_s1_wdata",   m1.wdata, 32'h5A);
      chk("t2_s1_wstrb",   32'(m1.wstrb), 1);
      m1.awready = 1; m1.wready = 1; #1;
      chk("t2_awready", 32'(up.awready), 1);
      chk("t2_wready",  32'(up.wready), 1);
      tick();
      up.awvalid = 0; up.wvalid = 0; m1.awready = 0; m1.wready = 0;
      m1.bvalid = 1; m1.bresp = 2'b00; #1;
      chk("t2_bvalid", 32'(up.bvalid), 1);
      chk("t2_bresp",  32'(up.bresp), 0);
      tick();
      m1.bvalid = 0; #1;
      chk("t2_bvalid_idle", 32'(up.bvalid), 0);
      chk("t2_s0_idle", 32'(s0_seen), 0);

      // 3) unmapped read
      clr_mon();
      up.araddr = 32'h2000_0000; up.arvalid = 1; up.rready = 0;
      tick();
      chk("t3_arready", 32'(up.arready), 1);
      tick();
      up.arvalid = 0; #1;
      chk("t3_arready_1cyc", 32'(up.arready), 0);
      chk("t3_rvalid", 32'(up.rvalid), 1);
      chk("t3_rresp",  32'(up.rresp), 3);
      chk("t3_rdata",  up.rdata, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_rvalid_hold", 32'(up.rvalid), 1);
      end
      up.rready = 1;
      tick();
      chk("t3_rvalid_done", 32'(up.rvalid), 0);
      chk("t3_no_down", 32'(s0_seen | s1_seen), 0);

      // 4a) unmapped write, W offered 3 cycles ahead of AW
      clr_mon();
      up.bready = 0; up.wvalid = 1; up.wdata = 0;
      tick(); tick(); tick();
      chk("t4_wready_idle", 32'(up.wready), 0);
      up.awaddr = 32'h3000_0000; up.awvalid = 1; #1;
      chk("t4_awready_bubble", 32'(up.awready), 0);
      tick();
      chk("t4_awready", 32'(up.awready), 1);
      chk("t4_wready",  32'(up.wready), 1);
      tick();
      up.awvalid = 0; up.wvalid = 0; #1;
      chk("t4_bvalid", 32'(up.bvalid), 1);
      chk("t4_bresp",  32'(up.bresp), 3);
      tick();
      chk("t4_bvalid_hold", 32'(up.bvalid), 1);
      up.bready = 1;
      tick();
      chk("t4_bvalid_done", 32'(up.bvalid), 0);
      chk("t4_single_b", 32'(b_hs), 1);
      chk("t4_no_down", 32'(s0_seen | s1_seen), 0);

      // 4b) unmapped write, AW first: its ready must drop once done
      up.awaddr = 32'h3000_0000; up.awvalid = 1;
      tick();
      chk("t4b_awready", 32'(up.awready), 1);
      tick();
      chk("t4b_aw_sticky", 32'(up.awready), 0);
      chk("t4b_no_b_yet",  32'(up.bvalid), 0);
      up.wvalid = 1; #1;
      chk("t4b_wready", 32'(up.wready), 1);
      tick();
      up.awvalid = 0; up.wvalid = 0; #1;
      chk("t4b_bvalid", 32'(up.bvalid), 1);
      tick();

      // 5) simultaneous read (s0) and write (s1): read first
      clr_mon();
      up.araddr = 32'h0000_0000; up.arvalid = 1; up.rready = 1;
      up.awaddr = 32'h1000_0000; up.awvalid = 1;
      up.wdata = 32'h77; up.wstrb = 4'hF; up.wvalid = 1; up.bready = 1;
      tick();
      chk("t5_s0_arvalid", 32'(m0.arvalid), 1);
      chk("t5_s1_aw_wait", 32'(m1.awvalid), 0);
      m0.arready = 1;
      tick();
      up.arvalid = 0; m0.arready = 0;
      m0.rvalid = 1; m0.rdata = 32'h0000_1234; #1;
      chk("t5_rdata", up.rdata, 32'h0000_1234);
      tick();
      m0.rvalid = 0; #1;
      chk("t5_aw_bubble", 32'(m1.awvalid), 0);
      tick();
      chk("t5_s1_awvalid", 32'(m1.awvalid), 1);
      chk("t5_s1_awaddr",  m1.awaddr, 32'h1000_0000);
      m1.awready = 1; m1.wready = 1;
      tick();
      up.awvalid = 0; up.wvalid = 0; m1.awready = 0; m1.wready = 0;
      m1.bvalid = 1; #1;
      chk("t5_bvalid", 32'(up.bvalid), 1);
      tick();
      m1.bvalid = 0;

      // 6) reset while waiting on s1 read data
      up.araddr = 32'h1000_0008; up.arvalid = 1; up.rready = 1;
      tick();
      m1.arready = 1;
      tick();
      up.arvalid = 0; m1.arready = 0; #1;
      chk("t6_s1_rready", 32'(m1.rready), 1);
      rst = 1;
      tick();
      rst = 0; #1;
      chk("t6_rst_s1_rready", 32'(m1.rready), 0);
      chk("t6_rst_rvalid",    32'(up.rvalid), 0);
      chk("t6_rst_arready",   32'(up.arready), 0);
      up.araddr = 32'h0000_0020; up.arvalid = 1;
      tick();
      chk("t6_s0_arvalid", 32'(m0.arvalid), 1);
      chk("t6_s0_araddr",  m0.araddr, 32'h0000_0020);
      m0.arready = 1;
      tick();
      up.arvalid = 0; m0.arready = 0;
      m0.rvalid = 1; m0.rdata = 32'hCAFE_F00D; #1;
      chk("t6_rdata", up.rdata, 32'hCAFE_F00D);
      tick();
      m0.rvalid = 0; #1;
      chk("t6_done", 32'(up.rvalid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
